// File: rtl/dispatch_queue.sv
// dispatch_queue: instruction FIFO between fetcher and ROB/RS/SLB. The head entry is
// decoded and issued combinationally once the ROB and its target station can accept it.
module dispatch_queue #(
  parameter int QUEUE_DEPTH = 8,
  parameter int ROB_TAG_W   = 4,
  parameter int OP_W        = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 in_fetcher_ce,
  input  logic [31:0]          in_fetcher_instr,
  input  logic [31:0]          in_fetcher_pc,
  input  logic                 in_fetcher_jump_ce,
  output logic                 out_fetcher_full,
  output logic [4:0]           out_reg_tag1,
  output logic [4:0]           out_reg_tag2,
  input  logic [31:0]          in_reg_value1,
  input  logic [31:0]          in_reg_value2,
  input  logic [ROB_TAG_W-1:0] in_reg_robtag1,
  input  logic [ROB_TAG_W-1:0] in_reg_robtag2,
  input  logic                 in_reg_busy1,
  input  logic                 in_reg_busy2,
  output logic [ROB_TAG_W-1:0] out_rob_fetch_tag1,
  output logic [ROB_TAG_W-1:0] out_rob_fetch_tag2,
  input  logic [31:0]          in_rob_fetch_value1,
  input  logic [31:0]          in_rob_fetch_value2,
  input  logic                 in_rob_fetch_ready1,
  input  logic                 in_rob_fetch_ready2,
  input  logic [ROB_TAG_W-1:0] in_rob_freetag,
  input  logic                 in_rob_full,
  input  logic                 in_rs_full,
  input  logic                 in_slb_full,
  input  logic                 in_alu_cdb_ce,
  input  logic                 in_slb_cdb_ce,
  input  logic [ROB_TAG_W-1:0] in_alu_cdb_tag,
  input  logic [ROB_TAG_W-1:0] in_slb_cdb_tag,
  input  logic [31:0]          in_alu_cdb_value,
  input  logic [31:0]          in_slb_cdb_value,
  input  logic                 in_rob_clear,
  output logic                 out_reg_ce,
  output logic [4:0]           out_reg_destination,
  output logic [ROB_TAG_W-1:0] out_reg_rob_tag,
  output logic                 out_rob_ce,
  output logic [4:0]           out_rob_destination,
  output logic [OP_W-1:0]      out_rob_op,
  output logic                 out_rob_jump_ce,
  output logic [31:0]          out_pc,
  output logic                 out_rs_ce,
  output logic [ROB_TAG_W-1:0] out_rs_rob_tag,
  output logic [OP_W-1:0]      out_rs_op,
  output logic [31:0]          out_rs_value1,
  output logic [31:0]          out_rs_value2,
  output logic [31:0]          out_rs_imm,
  output logic [ROB_TAG_W-1:0] out_rs_tag1,
  output logic [ROB_TAG_W-1:0] out_rs_tag2,
  output logic                 out_slb_ce,
  output logic [ROB_TAG_W-1:0] out_slb_rob_tag,
  output logic [OP_W-1:0]      out_slb_op,
  output logic [31:0]          out_slb_value1,
  output logic [31:0]          out_slb_value2,
  output logic [31:0]          out_slb_imm,
  output logic [ROB_TAG_W-1:0] out_slb_tag1,
  output logic [ROB_TAG_W-1:0] out_slb_tag2
);
  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int OPR_W = ROB_TAG_W + 32;

  // Internal opcode encoding; 0 marks an illegal instruction.
  localparam logic [OP_W-1:0] OP_LUI  = OP_W'(1),  OP_AUIPC = OP_W'(2),  OP_JAL  = OP_W'(3),
    OP_JALR = OP_W'(4),  OP_BEQ  = OP_W'(5),  OP_BNE  = OP_W'(6),  OP_BLT   = OP_W'(7),
    OP_BGE  = OP_W'(8),  OP_BLTU = OP_W'(9),  OP_BGEU = OP_W'(10), OP_LB    = OP_W'(11),
    OP_LH   = OP_W'(12), OP_LW   = OP_W'(13), OP_LBU  = OP_W'(14), OP_LHU   = OP_W'(15),
    OP_SB   = OP_W'(16), OP_SH   = OP_W'(17), OP_SW   = OP_W'(18), OP_ADDI  = OP_W'(19),
    OP_SLTI = OP_W'(20), OP_SLTIU= OP_W'(21), OP_XORI = OP_W'(22), OP_ORI   = OP_W'(23),
    OP_ANDI = OP_W'(24), OP_SLLI = OP_W'(25), OP_SRLI = OP_W'(26), OP_SRAI  = OP_W'(27),
    OP_ADD  = OP_W'(28), OP_SUB  = OP_W'(29), OP_SLL  = OP_W'(30), OP_SLT   = OP_W'(31),
    OP_SLTU = OP_W'(32), OP_XOR  = OP_W'(33), OP_SRL  = OP_W'(34), OP_SRA   = OP_W'(35),
    OP_OR   = OP_W'(36), OP_AND  = OP_W'(37);

  logic [QUEUE_DEPTH-1:0][31:0] r_instr, r_pc;
  logic [QUEUE_DEPTH-1:0]       r_jmp;
  logic [PTR_W-1:0]             r_head, r_tail;
  logic [PTR_W:0]               r_count;

  logic             w_nempty, w_push, w_pop, w_issue, w_drop, w_tgt_full;
  logic [31:0]      w_instr;
  logic [OP_W-1:0]  w_op;
  logic [31:0]      w_imm;
  logic             w_legal, w_use1, w_use2, w_wrd, w_slb;
  logic [OPR_W-1:0] w_opnd1, w_opnd2;

  assign w_nempty         = (r_count != '0);
  assign out_fetcher_full = (r_count == (PTR_W+1)'(QUEUE_DEPTH));
  assign w_instr          = w_nempty ? r_instr[r_head] : 32'd0;
  assign out_reg_tag1     = w_instr[19:15];
  assign out_reg_tag2     = w_instr[24:20];
  assign out_rob_fetch_tag1 = in_reg_robtag1;
  assign out_rob_fetch_tag2 = in_reg_robtag2;

  assign w_push     = rdy && !rst && in_fetcher_ce && !out_fetcher_full && !in_rob_clear;
  assign w_tgt_full = w_slb ? in_slb_full : in_rs_full;
  assign w_issue    = rdy && !rst && w_nempty && !in_rob_clear && !in_rob_full && !w_tgt_full && w_legal;
  assign w_drop     = rdy && !rst && w_nempty && !in_rob_clear && !w_legal;
  assign w_pop      = w_issue || w_drop;

  always_comb begin
    w_op = '0; w_imm = '0; w_use1 = 1'b0; w_use2 = 1'b0; w_wrd = 1'b0; w_slb = 1'b0;
    case (w_instr[6:0])
      7'b0110111: begin w_op = OP_LUI;   w_wrd = 1'b1; w_imm = {w_instr[31:12], 12'd0}; end
      7'b0010111: begin w_op = OP_AUIPC; w_wrd = 1'b1; w_imm = {w_instr[31:12], 12'd0}; end
      7'b1101111: begin
        w_op = OP_JAL; w_wrd = 1'b1;
        w_imm = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};
      end
      7'b1100111: begin
        if (w_instr[14:12] == 3'b000) w_op = OP_JALR;
        w_use1 = 1'b1; w_wrd = 1'b1; w_imm = {{20{w_instr[31]}}, w_instr[31:20]};
      end
      7'b1100011: begin
        case (w_instr[14:12])
          3'b000: w_op = OP_BEQ;  3'b001: w_op = OP_BNE;
          3'b100: w_op = OP_BLT;  3'b101: w_op = OP_BGE;
          3'b110: w_op = OP_BLTU; 3'b111: w_op = OP_BGEU;
          default: ;
        endcase
        w_use1 = 1'b1; w_use2 = 1'b1;
        w_imm = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
      end
      7'b0000011: begin
        case (w_instr[14:12])
          3'b000: w_op = OP_LB;  3'b001: w_op = OP_LH; 3'b010: w_op = OP_LW;
          3'b100: w_op = OP_LBU; 3'b101: w_op = OP_LHU;
          default: ;
        endcase
        w_use1 = 1'b1; w_wrd = 1'b1; w_slb = 1'b1; w_imm = {{20{w_instr[31]}}, w_instr[31:20]};
      end
      7'b0100011: begin
        case (w_instr[14:12])
          3'b000: w_op = OP_SB; 3'b001: w_op = OP_SH; 3'b010: w_op = OP_SW;
          default: ;
        endcase
        w_use1 = 1'b1; w_use2 = 1'b1; w_slb = 1'b1;
        w_imm = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
      end
      7'b0010011: begin
        w_use1 = 1'b1; w_wrd = 1'b1; w_imm = {{20{w_instr[31]}}, w_instr[31:20]};
        case (w_instr[14:12])
          3'b000: w_op = OP_ADDI; 3'b010: w_op = OP_SLTI; 3'b011: w_op = OP_SLTIU;
          3'b100: w_op = OP_XORI; 3'b110: w_op = OP_ORI;  3'b111: w_op = OP_ANDI;
          3'b001: begin
            if (w_instr[31:26] == 6'd0) w_op = OP_SLLI;
            w_imm = {26'd0, w_instr[25:20]};
          end
          default: begin
            if (!w_instr[31] && w_instr[29:26] == 4'd0) w_op = w_instr[30] ? OP_SRAI : OP_SRLI;
            w_imm = {26'd0, w_instr[25:20]};
          end
        endcase
      end
      7'b0110011: begin
        w_use1 = 1'b1; w_use2 = 1'b1; w_wrd = 1'b1;
        if (w_instr[31:25] == 7'b0000000) begin
          case (w_instr[14:12])
            3'b000: w_op = OP_ADD; 3'b001: w_op = OP_SLL; 3'b010: w_op = OP_SLT;
            3'b011: w_op = OP_SLTU; 3'b100: w_op = OP_XOR; 3'b101: w_op = OP_SRL;
            3'b110: w_op = OP_OR;  default: w_op = OP_AND;
          endcase
        end else if (w_instr[31:25] == 7'b0100000) begin
          if (w_instr[14:12] == 3'b000) w_op = OP_SUB;
          else if (w_instr[14:12] == 3'b101) w_op = OP_SRA;
        end
      end
      default: ;
    endcase
    w_legal = (w_op != '0);
  end

  // Returns {tag, value}; a CDB hit this cycle beats waiting on the ROB entry.
  function automatic logic [OPR_W-1:0] resolve(input logic [4:0] rs, input logic busy,
      input logic [ROB_TAG_W-1:0] tag, input logic [31:0] rval, input logic rrdy,
      input logic [31:0] rbval);
    if (rs == 5'd0)                                   resolve = '0;
    else if (!busy)                                   resolve = {{ROB_TAG_W{1'b0}}, rval};
    else if (rrdy)                                    resolve = {{ROB_TAG_W{1'b0}}, rbval};
    else if (in_alu_cdb_ce && in_alu_cdb_tag == tag)  resolve = {{ROB_TAG_W{1'b0}}, in_alu_cdb_value};
    else if (in_slb_cdb_ce && in_slb_cdb_tag == tag)  resolve = {{ROB_TAG_W{1'b0}}, in_slb_cdb_value};
    else                                              resolve = {tag, 32'd0};
  endfunction

  assign w_opnd1 = w_use1 ? resolve(w_instr[19:15], in_reg_busy1, in_reg_robtag1, in_reg_value1,
                                    in_rob_fetch_ready1, in_rob_fetch_value1) : '0;
  assign w_opnd2 = w_use2 ? resolve(w_instr[24:20], in_reg_busy2, in_reg_robtag2, in_reg_value2,
                                    in_rob_fetch_ready2, in_rob_fetch_value2) : '0;

  always_comb begin
    out_reg_ce = 1'b0; out_reg_destination = '0; out_reg_rob_tag = '0;
    out_rob_ce = 1'b0; out_rob_destination = '0; out_rob_op = '0; out_rob_jump_ce = 1'b0; out_pc = '0;
    out_rs_ce = 1'b0; out_rs_rob_tag = '0; out_rs_op = '0; out_rs_value1 = '0; out_rs_value2 = '0;
    out_rs_imm = '0; out_rs_tag1 = '0; out_rs_tag2 = '0;
    out_slb_ce = 1'b0; out_slb_rob_tag = '0; out_slb_op = '0; out_slb_value1 = '0; out_slb_value2 = '0;
    out_slb_imm = '0; out_slb_tag1 = '0; out_slb_tag2 = '0;
    if (w_issue) begin
      out_rob_ce = 1'b1; out_rob_op = w_op; out_rob_jump_ce = r_jmp[r_head]; out_pc = r_pc[r_head];
      out_rob_destination = w_wrd ? w_instr[11:7] : 5'd0;
      if (w_wrd && w_instr[11:7] != 5'd0) begin
        out_reg_ce = 1'b1; out_reg_destination = w_instr[11:7]; out_reg_rob_tag = in_rob_freetag;
      end
      if (w_slb) begin
        out_slb_ce = 1'b1; out_slb_rob_tag = in_rob_freetag; out_slb_op = w_op; out_slb_imm = w_imm;
        {out_slb_tag1, out_slb_value1} = w_opnd1;
        {out_slb_tag2, out_slb_value2} = w_opnd2;
      end else begin
        out_rs_ce = 1'b1; out_rs_rob_tag = in_rob_freetag; out_rs_op = w_op; out_rs_imm = w_imm;
        {out_rs_tag1, out_rs_value1} = w_opnd1;
        {out_rs_tag2, out_rs_value2} = w_opnd2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= '0; r_tail <= '0; r_count <= '0;
    end else if (rdy) begin
      if (in_rob_clear) begin
        r_head <= '0; r_tail <= '0; r_count <= '0;
      end else begin
        if (w_push) r_tail <= r_tail + PTR_W'(1);
        if (w_pop)  r_head <= r_head + PTR_W'(1);
        r_count <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr[r_tail] <= in_fetcher_instr;
      r_pc[r_tail]    <= in_fetcher_pc;
      r_jmp[r_tail]   <= in_fetcher_jump_ce;
    end
  end
endmodule

// File: tb/tb_dispatch_queue.sv
// Directed bench for dispatch_queue: decode/operand vector table plus FIFO corner sequences.
module tb_dispatch_queue;
  localparam int TW = 4;
  localparam logic [5:0] OP_LUI = 6'd1, OP_JAL = 6'd3, OP_BEQ = 6'd5, OP_LW = 6'd13, OP_SW = 6'd18,
    OP_ADDI = 6'd19, OP_SRAI = 6'd27, OP_ADD = 6'd28, OP_SUB = 6'd29;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rdy, in_fetcher_ce, in_fetcher_jump_ce, out_fetcher_full;
  logic [31:0] in_fetcher_instr, in_fetcher_pc;
  logic [4:0] out_reg_tag1, out_reg_tag2;
  logic [31:0] in_reg_value1, in_reg_value2, in_rob_fetch_value1, in_rob_fetch_value2;
  logic [TW-1:0] in_reg_robtag1, in_reg_robtag2, out_rob_fetch_tag1, out_rob_fetch_tag2;
  logic in_reg_busy1, in_reg_busy2, in_rob_fetch_ready1, in_rob_fetch_ready2;
  logic [TW-1:0] in_rob_freetag, in_alu_cdb_tag, in_slb_cdb_tag;
  logic in_rob_full, in_rs_full, in_slb_full, in_alu_cdb_ce, in_slb_cdb_ce, in_rob_clear;
  logic [31:0] in_alu_cdb_value, in_slb_cdb_value;
  logic out_reg_ce, out_rob_ce, out_rob_jump_ce, out_rs_ce, out_slb_ce;
  logic [4:0] out_reg_destination, out_rob_destination;
  logic [TW-1:0] out_reg_rob_tag, out_rs_rob_tag, out_rs_tag1, out_rs_tag2;
  logic [TW-1:0] out_slb_rob_tag, out_slb_tag1, out_slb_tag2;
  logic [5:0] out_rob_op, out_rs_op, out_slb_op;
  logic [31:0] out_pc, out_rs_value1, out_rs_value2, out_rs_imm;
  logic [31:0] out_slb_value1, out_slb_value2, out_slb_imm;

  dispatch_queue #(.QUEUE_DEPTH(8), .ROB_TAG_W(TW), .OP_W(6)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .in_fetcher_ce(in_fetcher_ce), .in_fetcher_instr(in_fetcher_instr), .in_fetcher_pc(in_fetcher_pc),
    .in_fetcher_jump_ce(in_fetcher_jump_ce), .out_fetcher_full(out_fetcher_full),
    .out_reg_tag1(out_reg_tag1), .out_reg_tag2(out_reg_tag2),
    .in_reg_value1(in_reg_value1), .in_reg_value2(in_reg_value2),
    .in_reg_robtag1(in_reg_robtag1), .in_reg_robtag2(in_reg_robtag2),
    .in_reg_busy1(in_reg_busy1), .in_reg_busy2(in_reg_busy2),
    .out_rob_fetch_tag1(out_rob_fetch_tag1), .out_rob_fetch_tag2(out_rob_fetch_tag2),
    .in_rob_fetch_value1(in_rob_fetch_value1), .in_rob_fetch_value2(in_rob_fetch_value2),
    .in_rob_fetch_ready1(in_rob_fetch_ready1), .in_rob_fetch_ready2(in_rob_fetch_ready2),
    .in_rob_freetag(in_rob_freetag), .in_rob_full(in_rob_full), .in_rs_full(in_rs_full),
    .in_slb_full(in_slb_full), .in_alu_cdb_ce(in_alu_cdb_ce), .in_slb_cdb_ce(in_slb_cdb_ce),
    .in_alu_cdb_tag(in_alu_cdb_tag), .in_slb_cdb_tag(in_slb_cdb_tag),
    .in_alu_cdb_value(in_alu_cdb_value), .in_slb_cdb_value(in_slb_cdb_value),
    .in_rob_clear(in_rob_clear),
    .out_reg_ce(out_reg_ce), .out_reg_destination(out_reg_destination), .out_reg_rob_tag(out_reg_rob_tag),
    .out_rob_ce(out_rob_ce), .out_rob_destination(out_rob_destination), .out_rob_op(out_rob_op),
    .out_rob_jump_ce(out_rob_jump_ce), .out_pc(out_pc),
    .out_rs_ce(out_rs_ce), .out_slb_ce(out_slb_ce),
    .out_rs_rob_tag(out_rs_rob_tag), .out_rs_op(out_rs_op), .out_rs_value1(out_rs_value1),
    .out_rs_value2(out_rs_value2), .out_rs_imm(out_rs_imm), .out_rs_tag1(out_rs_tag1), .out_rs_tag2(out_rs_tag2),
    .out_slb_rob_tag(out_slb_rob_tag), .out_slb_op(out_slb_op), .out_slb_value1(out_slb_value1),
    .out_slb_value2(out_slb_value2), .out_slb_imm(out_slb_imm), .out_slb_tag1(out_slb_tag1),
    .out_slb_tag2(out_slb_tag2)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    rdy = 1'b1; in_fetcher_ce = 1'b0; in_fetcher_instr = '0; in_fetcher_pc = '0; in_fetcher_jump_ce = 1'b0;
    in_reg_value1 = 32'h100; in_reg_value2 = 32'h200; in_reg_robtag1 = '0; in_reg_robtag2 = '0;
    in_reg_busy1 = 1'b0; in_reg_busy2 = 1'b0;
    in_rob_fetch_value1 = 32'h300; in_rob_fetch_value2 = 32'h400;
    in_rob_fetch_ready1 = 1'b0; in_rob_fetch_ready2 = 1'b0; in_rob_freetag = 4'd5;
    in_rob_full = 1'b0; in_rs_full = 1'b0; in_slb_full = 1'b0;
    in_alu_cdb_ce = 1'b0; in_slb_cdb_ce = 1'b0; in_alu_cdb_tag = '0; in_slb_cdb_tag = '0;
    in_alu_cdb_value = 32'h77; in_slb_cdb_value = 32'h55; in_rob_clear = 1'b0;
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc, input logic jmp);
    in_fetcher_ce = 1'b1; in_fetcher_instr = instr; in_fetcher_pc = pc; in_fetcher_jump_ce = jmp;
    tick();
    in_fetcher_ce = 1'b0;
  endtask

  typedef struct {
    string name; logic [31:0] instr;
    logic b1; logic [3:0] t1; logic r1; logic b2; logic [3:0] t2;
    logic alu; logic [3:0] alut; logic slbc; logic [3:0] slbt;
    logic e_rs, e_slb, e_reg; logic [5:0] e_op; logic [31:0] e_imm, e_v1; logic [3:0] e_t1;
    logic [31:0] e_v2; logic [3:0] e_t2; logic [4:0] e_dst;
  } vec_t;

  localparam int NV = 12;
  vec_t vt [NV];

  initial begin
    vt[0]  = '{"addi",     32'h00500093, 0,0,0, 0,0, 0,0, 0,0, 1,0,1, OP_ADDI, 32'd5, 32'h0, 0, 32'h0, 0, 5'd1};
    vt[1]  = '{"add_cdb",  32'h002081B3, 1,3,0, 0,0, 1,3, 0,0, 1,0,1, OP_ADD, 32'd0, 32'h77, 0, 32'h200, 0, 5'd3};
    vt[2]  = '{"add_wait", 32'h002081B3, 1,3,0, 0,0, 0,0, 0,0, 1,0,1, OP_ADD, 32'd0, 32'h0, 3, 32'h200, 0, 5'd3};
    vt[3]  = '{"sub_rob",  32'h402081B3, 1,3,1, 1,4, 0,0, 1,4, 1,0,1, OP_SUB, 32'd0, 32'h300, 0, 32'h55, 0, 5'd3};
    vt[4]  = '{"sw",       32'h0020A423, 0,0,0, 0,0, 0,0, 0,0, 0,1,0, OP_SW, 32'd8, 32'h100, 0, 32'h200, 0, 5'd0};
    vt[5]  = '{"lw_neg",   32'hFFC12283, 0,0,0, 0,0, 0,0, 0,0, 0,1,1, OP_LW, 32'hFFFFFFFC, 32'h100, 0, 32'h0, 0, 5'd5};
    vt[6]  = '{"srai",     32'h4030D213, 0,0,0, 0,0, 0,0, 0,0, 1,0,1, OP_SRAI, 32'd3, 32'h100, 0, 32'h0, 0, 5'd4};
    vt[7]  = '{"beq",      32'hFE208CE3, 0,0,0, 0,0, 0,0, 0,0, 1,0,0, OP_BEQ, 32'hFFFFFFF8, 32'h100, 0, 32'h200, 0, 5'd0};
    vt[8]  = '{"lui",      32'h123453B7, 0,0,0, 0,0, 0,0, 0,0, 1,0,1, OP_LUI, 32'h12345000, 32'h0, 0, 32'h0, 0, 5'd7};
    vt[9]  = '{"jal",      32'h010000EF, 0,0,0, 0,0, 0,0, 0,0, 1,0,1, OP_JAL, 32'd16, 32'h0, 0, 32'h0, 0, 5'd1};
    vt[10] = '{"addi_x0",  32'h00108013, 0,0,0, 0,0, 0,0, 0,0, 1,0,0, OP_ADDI, 32'd1, 32'h100, 0, 32'h0, 0, 5'd0};
    vt[11] = '{"add_slbcdb",32'h002081B3,1,3,0, 0,0, 1,2, 1,3, 1,0,1, OP_ADD, 32'd0, 32'h55, 0, 32'h200, 0, 5'd3};

    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0; #1;
    chk("rst.full", out_fetcher_full, 0);
    chk("rst.ce", {out_rob_ce, out_rs_ce, out_slb_ce, out_reg_ce}, 0);
    chk("rst.payload", out_rs_op | out_rs_imm | out_pc | out_slb_imm, 0);
    chk("rst.regtag", out_reg_tag1, 0);

    // decode and operand-resolution vectors; each entry pushed into an empty queue
    for (int i = 0; i < NV; i++) begin
      idle();
      push(vt[i].instr, 32'h1000 + 32'(i * 4), 1'b0);
      in_reg_busy1 = vt[i].b1; in_reg_robtag1 = vt[i].t1; in_rob_fetch_ready1 = vt[i].r1;
      in_reg_busy2 = vt[i].b2; in_reg_robtag2 = vt[i].t2;
      in_alu_cdb_ce = vt[i].alu; in_alu_cdb_tag = vt[i].alut;
      in_slb_cdb_ce = vt[i].slbc; in_slb_cdb_tag = vt[i].slbt;
      #1;
      chk({vt[i].name, ".rs_ce"}, out_rs_ce, vt[i].e_rs);
      chk({vt[i].name, ".slb_ce"}, out_slb_ce, vt[i].e_slb);
      chk({vt[i].name, ".rob_ce"}, out_rob_ce, 1);
      chk({vt[i].name, ".reg_ce"}, out_reg_ce, vt[i].e_reg);
      chk({vt[i].name, ".reg_tag"}, out_reg_rob_tag, vt[i].e_reg ? 32'd5 : 32'd0);
      chk({vt[i].name, ".rob_dst"}, out_rob_destination, vt[i].e_dst);
      chk({vt[i].name, ".rob_op"}, out_rob_op, vt[i].e_op);
      chk({vt[i].name, ".pc"}, out_pc, 32'h1000 + 32'(i * 4));
      chk({vt[i].name, ".op"}, vt[i].e_slb ? out_slb_op : out_rs_op, vt[i].e_op);
      chk({vt[i].name, ".imm"}, vt[i].e_slb ? out_slb_imm : out_rs_imm, vt[i].e_imm);
      chk({vt[i].name, ".v1"}, vt[i].e_slb ? out_slb_value1 : out_rs_value1, vt[i].e_v1);
      chk({vt[i].name, ".t1"}, vt[i].e_slb ? out_slb_tag1 : out_rs_tag1, vt[i].e_t1);
      chk({vt[i].name, ".v2"}, vt[i].e_slb ? out_slb_value2 : out_rs_value2, vt[i].e_v2);
      chk({vt[i].name, ".t2"}, vt[i].e_slb ? out_slb_tag2 : out_rs_tag2, vt[i].e_t2);
      chk({vt[i].name, ".robtag"}, vt[i].e_slb ? out_slb_rob_tag : out_rs_rob_tag, 5);
      tick();
    end

    // fill to full behind a busy RS, drop the 9th push, then drain in order
    idle(); in_rs_full = 1'b1;
    for (int i = 0; i < 8; i++) push(32'h00500093, 32'(i * 4), i[0]);
    chk("fill.full", out_fetcher_full, 1);
    chk("fill.stall", out_rob_ce, 0);
    push(32'h00500093, 32'h20, 1'b0);
    chk("fill.full9", out_fetcher_full, 1);
    in_rs_full = 1'b0; #1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d.ce", i), out_rs_ce, 1);
      chk($sformatf("drain%0d.pc", i), out_pc, 32'(i * 4));
      chk($sformatf("drain%0d.jmp", i), out_rob_jump_ce, i[0]);
      tick();
      if (i == 0) chk("drain.full_drop", out_fetcher_full, 0);
    end
    chk("drain.empty_ce", out_rob_ce, 0);
    chk("drain.empty_payload", out_pc | out_rs_imm, 0);

    // store stalled on SLB full
    idle(); in_slb_full = 1'b1;
    push(32'h0020A423, 32'h80, 1'b0);
    chk("stall.slb_ce", out_slb_ce, 0);
    tick();
    chk("stall.rob_ce", out_rob_ce, 0);
    in_slb_full = 1'b0; #1;
    chk("stall.rel_slb", out_slb_ce, 1);
    chk("stall.rel_rs", out_rs_ce, 0);
    chk("stall.rel_reg", out_reg_ce, 0);
    chk("stall.rel_imm", out_slb_imm, 8);
    tick();

    // clear with 5 queued and a simultaneous push
    idle(); in_rob_full = 1'b1;
    for (int i = 0; i < 5; i++) push(32'h00500093, 32'h100 + 32'(i * 4), 1'b0);
    in_rob_clear = 1'b1; in_fetcher_ce = 1'b1; in_fetcher_instr = 32'h00500093; in_fetcher_pc = 32'h1FC;
    in_rob_full = 1'b0; #1;
    chk("clr.same_cycle_ce", out_rob_ce, 0);
    tick();
    in_rob_clear = 1'b0; in_fetcher_ce = 1'b0; #1;
    chk("clr.empty_ce", out_rob_ce | out_rs_ce, 0);
    chk("clr.regtag", out_reg_tag2, 0);
    push(32'h123453B7, 32'h200, 1'b0);
    chk("clr.after_ce", out_rs_ce, 1);
    chk("clr.after_pc", out_pc, 32'h200);
    tick();

    // illegal opcode popped with nothing issued, followed LUI issues
    idle();
    push(32'h0000007F, 32'h300, 1'b0);
    in_fetcher_ce = 1'b1; in_fetcher_instr = 32'h123453B7; in_fetcher_pc = 32'h304; #1;
    chk("ill.ce", {out_rob_ce, out_rs_ce, out_slb_ce, out_reg_ce}, 0);
    tick();
    in_fetcher_ce = 1'b0; #1;
    chk("ill.lui_ce", out_rs_ce, 1);
    chk("ill.lui_imm", out_rs_imm, 32'h12345000);
    chk("ill.lui_pc", out_pc, 32'h304);
    tick();
    chk("ill.empty", out_rob_ce, 0);

    // rdy low holds the queue
    idle();
    push(32'h00500093, 32'h400, 1'b0);
    rdy = 1'b0; #1;
    chk("rdy.low_ce", out_rs_ce, 0);
    tick(); tick();
    rdy = 1'b1; #1;
    chk("rdy.resume_ce", out_rs_ce, 1);
    chk("rdy.resume_pc", out_pc, 32'h400);
    tick();
    chk("rdy.empty", out_rob_ce, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
